// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader_pkg
// Description : Shared types and constants for the ROM download loader.
//               The FSM state enum, the default address regions, the download
//               stream indexes and an address region helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  localparam logic [24:0] SP_BASE_DEF   = 25'h30000;
  localparam logic [24:0] PROM_BASE_DEF = 25'hA0000;
  localparam logic [24:0] PROM_END_DEF  = 25'hA0920;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;

  // Half-open region test: lo <= a < hi
  function automatic logic in_region(input logic [24:0] a,
                                     input logic [24:0] lo,
                                     input logic [24:0] hi);
    return (a >= lo) && (a < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_port.sv
`default_nettype none
// ============================================================================
// Module      : toggle_port
// Description : Toggle-handshake request holder for one SDRAM port. A fire
//               pulse flips req; done is high whenever ack has caught up.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_port (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic ack,
  output logic req,
  output logic done
);

  logic req_q;
  logic req_d;

  // Next request level: flip on fire, otherwise hold
  always_comb begin
    req_d = req_q;
    if (fire) begin
      req_d = ~req_q;
    end
  end

  // Request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req  = req_q;
  assign done = (req_q == ack);

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Moves HPS download bytes into SDRAM through two toggle
//               handshake ports (port2 mirrors the sprite region), pulses
//               PROM writes for the colour/height region, latches the
//               core_mod byte and flags completed ROM downloads.
//               Optional macro ROMLOAD_TIMEOUT_EN adds an ack timeout and
//               the sticky dl_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [24:0] SP_BASE   = SP_BASE_DEF,
  parameter logic [24:0] PROM_BASE = PROM_BASE_DEF,
  parameter logic [24:0] PROM_END  = PROM_END_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  sdr_ds,
  output logic [15:0] sdr_d,
  output logic        sdr_we,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic [7:0]  core_mod,
`ifdef ROMLOAD_TIMEOUT_EN
  output logic        dl_err,
`endif
  output logic        rom_loaded
);

  // Registered copies of the HPS inputs; the strobe edge is detected on these
  logic        in_wr_q, in_dl_q;
  logic [7:0]  in_idx_q, in_dout_q;
  logic [24:0] in_addr_q;

  state_e      state_q, state_d;
  logic        wr_prev_q, act_prev_q;
  logic        wait_q, wait_d;
  logic        use_p2_q, use_p2_d;
  logic        prom_wr_q, prom_wr_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  logic [22:0] port1_a_q, port1_a_d;
  logic [22:0] port2_a_q, port2_a_d;
  logic [1:0]  sdr_ds_q, sdr_ds_d;
  logic [15:0] sdr_d_q, sdr_d_d;
  logic [7:0]  core_mod_q, core_mod_d;
  logic        rom_loaded_q, rom_loaded_d;
`ifdef ROMLOAD_TIMEOUT_EN
  logic [11:0] tmo_cnt_q, tmo_cnt_d;
  logic        dl_err_q, dl_err_d;
`endif

  logic        w_rise, w_act_now, w_fire1, w_fire2;
  logic        w_p1_done, w_p2_done, w_all_done;
  logic [24:0] w_sp_off, w_prom_off;
  logic        w_unused_bits;

  assign w_rise     = in_wr_q & ~wr_prev_q;
  assign w_act_now  = in_dl_q & (in_idx_q == IDX_ROM);
  assign w_sp_off   = in_addr_q - SP_BASE;
  assign w_prom_off = in_addr_q - PROM_BASE;
  assign w_all_done = w_p1_done & (~use_p2_q | w_p2_done);
  assign w_unused_bits = &{1'b0, w_sp_off[24], w_sp_off[0], w_prom_off[24:12]};

  toggle_port u_port1 (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .fire  (w_fire1),
    .ack   (port1_ack),
    .req   (port1_req),
    .done  (w_p1_done)
  );

  toggle_port u_port2 (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .fire  (w_fire2),
    .ack   (port2_ack),
    .req   (port2_req),
    .done  (w_p2_done)
  );

  // Next-state, capture and handshake control
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    use_p2_d     = use_p2_q;
    prom_wr_d    = 1'b0;
    prom_addr_d  = prom_addr_q;
    prom_data_d  = prom_data_q;
    port1_a_d    = port1_a_q;
    port2_a_d    = port2_a_q;
    sdr_ds_d     = sdr_ds_q;
    sdr_d_d      = sdr_d_q;
    core_mod_d   = core_mod_q;
    rom_loaded_d = rom_loaded_q | (act_prev_q & ~w_act_now);
    w_fire1      = 1'b0;
    w_fire2      = 1'b0;
`ifdef ROMLOAD_TIMEOUT_EN
    tmo_cnt_d    = 12'd0;
    dl_err_d     = dl_err_q;
`endif

    // core_mod byte is independent of the SDRAM path
    if (w_rise && (in_idx_q == IDX_MOD) && (in_addr_q == 25'd0)) begin
      core_mod_d = in_dout_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_rise && in_dl_q && (in_idx_q == IDX_ROM)) begin
          state_d   = ST_ISSUE;
          wait_d    = 1'b1;
          use_p2_d  = (in_addr_q >= SP_BASE);
          port1_a_d = in_addr_q[23:1];
          port2_a_d = w_sp_off[23:1];
          sdr_ds_d  = {in_addr_q[0], ~in_addr_q[0]};
          sdr_d_d   = {in_dout_q, in_dout_q};
          if (in_region(in_addr_q, PROM_BASE, PROM_END)) begin
            prom_wr_d   = 1'b1;
            prom_addr_d = w_prom_off[11:0];
            prom_data_d = in_dout_q;
          end
        end
      end
      ST_ISSUE: begin
        w_fire1 = 1'b1;
        w_fire2 = use_p2_q;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (w_all_done) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end
`ifdef ROMLOAD_TIMEOUT_EN
        else if (tmo_cnt_q == 12'd4094) begin
          state_d  = ST_IDLE;
          wait_d   = 1'b0;
          dl_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 12'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in_wr_q      <= 1'b0;
      in_dl_q      <= 1'b0;
      in_idx_q     <= 8'd0;
      in_addr_q    <= 25'd0;
      in_dout_q    <= 8'd0;
      state_q      <= ST_IDLE;
      wr_prev_q    <= 1'b0;
      act_prev_q   <= 1'b0;
      wait_q       <= 1'b0;
      use_p2_q     <= 1'b0;
      prom_wr_q    <= 1'b0;
      prom_addr_q  <= 12'd0;
      prom_data_q  <= 8'd0;
      port1_a_q    <= 23'd0;
      port2_a_q    <= 23'd0;
      sdr_ds_q     <= 2'd0;
      sdr_d_q      <= 16'd0;
      core_mod_q   <= 8'h00;
      rom_loaded_q <= 1'b0;
`ifdef ROMLOAD_TIMEOUT_EN
      tmo_cnt_q    <= 12'd0;
      dl_err_q     <= 1'b0;
`endif
    end else begin
      in_wr_q      <= ioctl_wr;
      in_dl_q      <= ioctl_download;
      in_idx_q     <= ioctl_index;
      in_addr_q    <= ioctl_addr;
      in_dout_q    <= ioctl_dout;
      state_q      <= state_d;
      wr_prev_q    <= in_wr_q;
      act_prev_q   <= w_act_now;
      wait_q       <= wait_d;
      use_p2_q     <= use_p2_d;
      prom_wr_q    <= prom_wr_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      port1_a_q    <= port1_a_d;
      port2_a_q    <= port2_a_d;
      sdr_ds_q     <= sdr_ds_d;
      sdr_d_q      <= sdr_d_d;
      core_mod_q   <= core_mod_d;
      rom_loaded_q <= rom_loaded_d;
`ifdef ROMLOAD_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      dl_err_q     <= dl_err_d;
`endif
    end
  end

  assign ioctl_wait = wait_q;
  assign port1_a    = port1_a_q;
  assign port2_a    = port2_a_q;
  assign sdr_ds     = sdr_ds_q;
  assign sdr_d      = sdr_d_q;
  assign sdr_we     = w_act_now;
  assign prom_wr    = prom_wr_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign core_mod   = core_mod_q;
  assign rom_loaded = rom_loaded_q;
`ifdef ROMLOAD_TIMEOUT_EN
  assign dl_err     = dl_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Directed and randomized bench for rom_loader with an SDRAM
//               toggle-ack responder and an address-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  localparam int unsigned SPB = 32'h30000;
  localparam int unsigned PB  = 32'hA0000;
  localparam int unsigned PE  = 32'hA0920;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait, port1_req, port2_req, sdr_we, prom_wr, rom_loaded;
  logic        port1_ack, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  sdr_ds;
  logic [15:0] sdr_d;
  logic [11:0] prom_addr;
  logic [7:0]  prom_data, core_mod;
`ifdef ROMLOAD_TIMEOUT_EN
  logic        dl_err;
`endif

  rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .sdr_ds(sdr_ds), .sdr_d(sdr_d), .sdr_we(sdr_we), .prom_wr(prom_wr),
    .prom_addr(prom_addr), .prom_data(prom_data), .core_mod(core_mod),
`ifdef ROMLOAD_TIMEOUT_EN
    .dl_err(dl_err),
`endif
    .rom_loaded(rom_loaded)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n1 = 0, n2 = 0;
  logic [7:0]  exp_core = 8'h00;
  logic [11:0] exp_paddr = 12'd0;
  logic [7:0]  exp_pdata = 8'd0;

  // SDRAM responder
  bit hold_ack = 1'b0;
  int dly1 = 2, dly2 = 2;
  int c1 = 0, c2 = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        port1_ack = 1'b0; port2_ack = 1'b0; c1 = 0; c2 = 0;
      end else if (!hold_ack) begin
        if (port1_req !== port1_ack) begin
          c1++;
          if (c1 >= dly1) begin port1_ack = port1_req; c1 = 0; end
        end
        if (port2_req !== port2_ack) begin
          c2++;
          if (c2 >= dly2) begin port2_ack = port2_req; c2 = 0; end
        end
      end
    end
  end

  // One strobe plus the checks for the capture and issue cycles
  task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                      input string tag);
    int unsigned ai, p2off;
    bit rom, p2, ph;
    logic old1, old2;
    ai  = a;
    rom = ioctl_download && (idx == 8'd0);
    p2  = rom && (ai >= SPB);
    ph  = rom && (ai >= PB) && (ai < PE);
    if (idx == 8'd1 && ai == 0) exp_core = d;
    old1 = port1_req;
    old2 = port2_req;
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    chk({tag, "_wait_cap"}, ioctl_wait, rom);
    chk({tag, "_req_hold"}, {port1_req, port2_req}, {old1, old2});
    chk({tag, "_prom_wr"}, prom_wr, ph);
    @(posedge clk_sys); #1;
    if (rom) n1++;
    if (p2) n2++;
    if (ph) begin
      exp_paddr = 12'((ai - PB) % 4096);
      exp_pdata = d;
    end
    chk({tag, "_reqs"}, {port1_req, port2_req}, {(n1 % 2) != 0, (n2 % 2) != 0});
    chk({tag, "_prom_end"}, prom_wr, 1'b0);
    chk({tag, "_prom_ad"}, {prom_addr, prom_data}, {exp_paddr, exp_pdata});
    chk({tag, "_core_mod"}, core_mod, exp_core);
    chk({tag, "_wait_iss"}, ioctl_wait, rom);
    if (rom) begin
      chk({tag, "_p1a"}, port1_a, 23'((ai / 2) % (1 << 23)));
      chk({tag, "_ds"}, sdr_ds, (ai % 2) ? 2'b10 : 2'b01);
      chk({tag, "_sd"}, sdr_d, 16'(d * 257));
      if (p2) begin
        p2off = (ai - SPB) % (1 << 25);
        chk({tag, "_p2a"}, port2_a, 23'((p2off / 2) % (1 << 23)));
      end
    end
  endtask

  // Wait for the byte to complete; both handshakes must be balanced then
  task automatic drain(input string tag);
    int k;
    k = 0;
    while (ioctl_wait === 1'b1 && k < 300) begin
      @(posedge clk_sys); #1;
      k++;
    end
    chk({tag, "_drain"}, {ioctl_wait, port1_ack, port2_ack}, {1'b0, port1_req, port2_req});
  endtask

  initial begin
    logic [24:0] ra;
    logic [7:0]  ri;
    int          sel;
    logic [24:0] bnd [6];
    bnd[0] = 25'h2FFFF; bnd[1] = 25'h30000; bnd[2] = 25'h9FFFF;
    bnd[3] = 25'hA0000; bnd[4] = 25'hA091F; bnd[5] = 25'hA0920;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_outs",
        {port1_req, port2_req, ioctl_wait, prom_wr, rom_loaded, sdr_we, core_mod,
         sdr_ds, sdr_d, port1_a, port2_a, prom_addr, prom_data}, 128'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("sdr_we_on", sdr_we, 1'b1);

    // Plain low-region byte: port1 only
    send(8'd0, 25'h00010, 8'h5A, "b010");
    drain("b010");

    // Sprite-region byte with skewed acks: wait must span the slower port
    dly1 = 3; dly2 = 7;
    send(8'd0, 25'h30001, 8'hC3, "b30001");
    drain("b30001");
    dly1 = 2; dly2 = 2;

    // PROM pulse inside the region, none at its end
    send(8'd0, 25'hA0305, 8'h0F, "prom_in");
    drain("prom_in");
    send(8'd0, 25'hA0920, 8'h44, "prom_end");
    drain("prom_end");

    // Download window close sets rom_loaded
    chk("loaded_before", rom_loaded, 1'b0);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("loaded_after", rom_loaded, 1'b1);

    // core_mod stream and foreign indexes
    ioctl_download = 1'b1;
    send(8'd1, 25'd0, 8'h06, "mod_06");
    send(8'd1, 25'd1, 8'h99, "mod_a1");
    send(8'd254, 25'd0, 8'h77, "idx254");
    send(8'd254, 25'h00100, 8'h11, "idx254r");

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      dly1 = $urandom_range(1, 8);
      dly2 = $urandom_range(1, 8);
      sel  = $urandom_range(0, 9);
      ri   = (sel == 0) ? 8'd1 : (sel == 1) ? 8'd254 : 8'd0;
      case ($urandom_range(0, 4))
        0: ra = 25'($urandom_range(0, SPB - 1));
        1: ra = 25'(SPB + $urandom_range(0, 32'hFFFF));
        2: ra = 25'(PB + $urandom_range(0, PE - PB - 1));
        3: ra = bnd[$urandom_range(0, 5)];
        default: ra = 25'($urandom_range(0, 32'h1FFFFFF));
      endcase
      if (ri == 8'd1 && $urandom_range(0, 1) == 0) ra = 25'd0;
      send(ri, ra, 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
      drain($sformatf("rnd%0d", i));
    end
    chk("loaded_sticky", rom_loaded, 1'b1);
    dly1 = 2; dly2 = 2;

`ifdef ROMLOAD_TIMEOUT_EN
    begin
      int k;
      hold_ack = 1'b1;
      send(8'd0, 25'h00100, 8'h11, "tmo");
      k = 0;
      while (ioctl_wait === 1'b1 && k < 5000) begin
        @(posedge clk_sys); #1;
        k++;
      end
      chk("tmo_err", dl_err, 1'b1);
      chk("tmo_len", (k >= 4085) && (k <= 4100), 1'b1);
    end
`endif

    // Reset during WAIT_ACK abandons the byte
    hold_ack = 1'b1;
    send(8'd0, 25'h30044, 8'h99, "rst_byte");
    @(posedge clk_sys);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {port1_req, port2_req, ioctl_wait, prom_wr, rom_loaded, sdr_we, core_mod,
         sdr_ds, sdr_d, port1_a, port2_a, prom_addr, prom_data}, 128'd0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    hold_ack = 1'b0;
    n1 = 0; n2 = 0;
    exp_core = 8'h00; exp_paddr = 12'd0; exp_pdata = 8'd0;
    send(8'd0, 25'h00021, 8'hA5, "post_rst");
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter SP_BASE, 25'h30000, first byte address also mirrored to SDRAM port2.
REQ-002 Parameter PROM_BASE, 25'hA0000, first byte address of the colour/height PROM region.
REQ-003 Parameter PROM_END, 25'hA0920, first byte address past the PROM region.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ioctl_download  in  1  download window active.
REQ-007 ioctl_index  in  8  download stream index: 0 = ROM, 1 = core_mod byte.
REQ-008 ioctl_wr  in  1  byte strobe; level signal, captured on its rising edge.
REQ-009 ioctl_addr  in  25  byte address.
REQ-010 ioctl_dout  in  8  byte data.
REQ-011 ioctl_wait  out  1  backpressure to the HPS while a byte is in flight.
REQ-012 port1_req  out  1  SDRAM port1 toggle request.
REQ-013 port1_ack  in  1  SDRAM port1 toggle acknowledge.
REQ-014 port1_a  out  23  port1 word address = addr[23:1].
REQ-015 port2_req  out  1  SDRAM port2 toggle request.
REQ-016 port2_ack  in  1  SDRAM port2 toggle acknowledge.
REQ-017 port2_a  out  23  port2 word address = (addr - SP_BASE)[23:1].
REQ-018 sdr_ds  out  2  byte selects {addr[0], ~addr[0]}, shared by both ports.
REQ-019 sdr_d  out  16  {byte, byte}, shared by both ports.
REQ-020 sdr_we  out  1  write enable, high while a ROM download is active.
REQ-021 prom_wr  out  1  single-cycle PROM write pulse.
REQ-022 prom_addr  out  12  (addr - PROM_BASE)[11:0].
REQ-023 prom_data  out  8  PROM byte.
REQ-024 core_mod  out  8  hardware-variant select byte.
REQ-025 rom_loaded  out  1  sticky flag: a ROM download has completed.

Function
REQ-026 FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE→ISSUE on a rising edge of ioctl_wr with ioctl_download=1 and index=0.
- ISSUE→WAIT_ACK after exactly one cycle.
- WAIT_ACK→IDLE when every toggled port's ack equals its req.
REQ-027 Capture in IDLE:
- Latch addr and data.
- ioctl_wait=1 from the cycle after the capture edge until the cycle WAIT_ACK exits.
REQ-028 ISSUE:
- Always toggle port1_req.
- Also toggle port2_req when addr >= SP_BASE; equality counts as port2.
REQ-029 PROM pulse: when PROM_BASE <= addr < PROM_END, prom_wr=1 for exactly the ISSUE cycle with prom_addr/prom_data valid. The SDRAM write still occurs.
REQ-030 Latency: req toggles 2 cycles after the ioctl_wr rising edge is sampled.
REQ-031 Strobes arriving while not IDLE are ignored. ioctl_wait forbids them.
REQ-032 Index 1: on an ioctl_wr rising edge with addr==0, latch core_mod<=data. No SDRAM access, no wait.
REQ-033 Other indexes (including 254) are ignored entirely.
REQ-034 rom_loaded sets on the falling edge of (ioctl_download & index==0) and stays set until reset.
REQ-035 Download dropping mid-WAIT_ACK: the FSM still waits for ack, so req/ack parity is never lost.
REQ-036 Address wrap: port2_a is computed modulo 2^25 and is used only when addr >= SP_BASE.

Reset
REQ-037 Asynchronous clear on reset_n=0:
- FSM=IDLE; port1_req, port2_req, ioctl_wait, prom_wr, rom_loaded = 0.
- core_mod=8'h00; sdr_ds, sdr_d, port1_a, port2_a, prom_addr, prom_data = 0.
- Edge detector primed with ioctl_wr=0.
REQ-038 Reset mid-transfer abandons the byte. The req/ack outputs return to 0, and the SDRAM is reset by the same reset_n.

Configuration
REQ-039 ROMLOAD_TIMEOUT_EN defined:
- 12-bit counter in WAIT_ACK; after 4095 cycles without ack, force IDLE and set sticky output dl_err (out, 1, reset 0).
- Undefined: no counter, no dl_err port; wait indefinitely.

Structure
REQ-040 Shared package rom_loader_pkg: FSM state enum, default region constants, index constants IDX_ROM=0 and IDX_MOD=1.
REQ-041 One sub-module, toggle_port, instantiated twice: holds req, compares against ack, reports done.

Verification
REQ-042 Index 0, addr 0x00010, data 0x5A → port1_req toggles at +2 cycles, port1_a=0x8, sdr_ds=2'b01, sdr_d=0x5A5A, port2 unchanged.
REQ-043 addr 0x30001, data 0xC3 → both reqs toggle, port2_a=0x0, sdr_ds=2'b10. ioctl_wait holds until both acks are returned, with ack delays of 3 and 7 cycles.
REQ-044 addr 0xA0305, data 0x0F → one prom_wr pulse, prom_addr=0x305, prom_data=0x0F. addr 0xA0920 → no pulse.
REQ-045 Index 1, addr 0, data 0x06 → core_mod=0x06, no req toggle. Index 254 → no effect.
REQ-046 reset_n low during WAIT_ACK → all outputs 0 next edge. Download 0→1→0 with index 0 → rom_loaded=1. Under ROMLOAD_TIMEOUT_EN, ack withheld → dl_err=1 after 4095 cycles.
